dvs_event_scheduler: RTL and testbench

Sits between dvs_aer_receiver and the RAVENS spike input port. Accepts single-cycle new_event pulses carrying x/y/timestamp/polarity and pools x/y onto a coarse neuron grid. Suppresses repeats of the same neuron/polarity inside a refractory window. Buffers accepted events in a FIFO and releases them in order over a valid/ready spike interface, counting dropped events.

---
 rtl/dvs_event_scheduler.sv | 163 ++++++++++++++++
 tb/tb_dvs_event_scheduler.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/dvs_event_scheduler.sv
// DVS event scheduler: pools AER events onto a neuron grid, suppresses refractory
// repeats, buffers accepted events in a FIFO and releases them over valid/ready.
module dvs_event_scheduler #(
  parameter int FIFO_DEPTH        = 16,
  parameter int POOL_SHIFT        = 2,
  parameter int REFRACTORY_US     = 8,
  parameter int DVS_X_ADDR_BITS   = 8,
  parameter int DVS_Y_ADDR_BITS   = 8,
  parameter int TIMESTAMP_US_BITS = 16,
  localparam int NEURON_ID_BITS   = DVS_X_ADDR_BITS + DVS_Y_ADDR_BITS - 2*POOL_SHIFT,
  localparam int CNT_W            = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         flush,
  input  logic [DVS_X_ADDR_BITS-1:0]   event_x,
  input  logic [DVS_Y_ADDR_BITS-1:0]   event_y,
  input  logic [TIMESTAMP_US_BITS-1:0] event_timestamp,
  input  logic                         event_polarity,
  input  logic                         new_event,
  output logic                         spike_valid,
  input  logic                         spike_ready,
  output logic [NEURON_ID_BITS-1:0]    spike_neuron_id,
  output logic                         spike_polarity,
  output logic [TIMESTAMP_US_BITS-1:0] spike_timestamp,
  output logic [CNT_W-1:0]             fifo_count,
  output logic [15:0]                  drop_count,
  output logic                         busy
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = NEURON_ID_BITS + 1 + TIMESTAMP_US_BITS;
  localparam logic [TIMESTAMP_US_BITS:0] REFRACTORY = (TIMESTAMP_US_BITS+1)'(REFRACTORY_US);

  typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_e;

  out_state_e                   out_state_q, out_state_d;
  logic [ENTRY_W-1:0]           out_data_q, out_data_d;
  logic [ENTRY_W-1:0]           mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]             fifo_count_q, fifo_count_d;
  logic [15:0]                  drop_count_q, drop_count_d;
  logic [NEURON_ID_BITS-1:0]    last_id_q, last_id_d;
  logic                         last_pol_q, last_pol_d;
  logic [TIMESTAMP_US_BITS-1:0] last_ts_q, last_ts_d;
  logic                         last_valid_q, last_valid_d;

  logic [NEURON_ID_BITS-1:0]    cand_id;
  logic [TIMESTAMP_US_BITS-1:0] ts_diff;
  logic candidate, suppress, accept, fifo_full, fifo_empty, push, pop;
  logic unused_pool_lsbs;

  assign cand_id = {event_y[DVS_Y_ADDR_BITS-1:POOL_SHIFT], event_x[DVS_X_ADDR_BITS-1:POOL_SHIFT]};
  assign unused_pool_lsbs = ^{event_y[POOL_SHIFT-1:0], event_x[POOL_SHIFT-1:0]};

  // Timestamp distance is unsigned and wraps, so history survives counter rollover.
  always_comb begin
    candidate  = new_event && enable && !flush;
    ts_diff    = event_timestamp - last_ts_q;
    suppress   = (REFRACTORY_US != 0) && last_valid_q && (cand_id == last_id_q) &&
                 (event_polarity == last_pol_q) && ({1'b0, ts_diff} < REFRACTORY);
    accept     = candidate && !suppress;
    fifo_full  = (fifo_count_q == CNT_W'(FIFO_DEPTH));
    fifo_empty = (fifo_count_q == '0);
    push       = accept && !fifo_full;
    pop        = !flush && !fifo_empty && ((out_state_q == OUT_EMPTY) || spike_ready);
  end

  always_comb begin
    last_id_d    = last_id_q;
    last_pol_d   = last_pol_q;
    last_ts_d    = last_ts_q;
    last_valid_d = last_valid_q;
    drop_count_d = drop_count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_count_d = fifo_count_q;
    out_state_d  = out_state_q;
    out_data_d   = out_data_q;

    if (flush) begin
      last_valid_d = 1'b0;
    end else if (accept) begin
      last_id_d    = cand_id;
      last_pol_d   = event_polarity;
      last_ts_d    = event_timestamp;
      last_valid_d = 1'b1;
    end

    if (accept && fifo_full && (drop_count_q != 16'hFFFF))
      drop_count_d = drop_count_q + 16'd1;

    if (flush) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      fifo_count_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count_d = fifo_count_q + CNT_W'(1);
        2'b01:   fifo_count_d = fifo_count_q - CNT_W'(1);
        default: fifo_count_d = fifo_count_q;
      endcase
    end

    // Output stage refills on the same edge as a handshake so spikes stream back to back.
    case (out_state_q)
      OUT_EMPTY: begin
        if (pop) begin
          out_state_d = OUT_FULL;
          out_data_d  = mem_q[rd_ptr_q];
        end
      end
      OUT_FULL: begin
        if (spike_ready) begin
          if (pop) out_data_d = mem_q[rd_ptr_q];
          else     out_state_d = OUT_EMPTY;
        end
      end
      default: out_state_d = OUT_EMPTY;
    endcase
    if (flush) out_state_d = OUT_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cand_id, event_polarity, event_timestamp};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_state_q  <= OUT_EMPTY;
      out_data_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
      drop_count_q <= '0;
      last_id_q    <= '0;
      last_pol_q   <= 1'b0;
      last_ts_q    <= '0;
      last_valid_q <= 1'b0;
    end else begin
      out_state_q  <= out_state_d;
      out_data_q   <= out_data_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
      drop_count_q <= drop_count_d;
      last_id_q    <= last_id_d;
      last_pol_q   <= last_pol_d;
      last_ts_q    <= last_ts_d;
      last_valid_q <= last_valid_d;
    end
  end

  assign spike_valid = (out_state_q == OUT_FULL);
  assign {spike_neuron_id, spike_polarity, spike_timestamp} = out_data_q;
  assign fifo_count  = fifo_count_q;
  assign drop_count  = drop_count_q;
  assign busy        = (fifo_count_q != '0) || spike_valid;

endmodule

// File: tb/tb_dvs_event_scheduler.sv
// Scoreboard bench for dvs_event_scheduler: directed events push expected spikes,
// a negedge monitor pops and compares on every spike handshake.
module tb_dvs_event_scheduler;

  logic        clk = 1'b0;
  logic        rst_n, enable, flush, new_event, event_polarity, spike_ready;
  logic [7:0]  event_x, event_y;
  logic [15:0] event_timestamp;
  logic        spike_valid, spike_polarity, busy;
  logic [11:0] spike_neuron_id;
  logic [15:0] spike_timestamp, drop_count;
  logic [4:0]  fifo_count;

  int checks = 0;
  int errors = 0;
  logic [28:0] expQ[$];

  always #5 clk = ~clk;

  dvs_event_scheduler #(
    .FIFO_DEPTH(16), .POOL_SHIFT(2), .REFRACTORY_US(8),
    .DVS_X_ADDR_BITS(8), .DVS_Y_ADDR_BITS(8), .TIMESTAMP_US_BITS(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
    .event_x(event_x), .event_y(event_y), .event_timestamp(event_timestamp),
    .event_polarity(event_polarity), .new_event(new_event),
    .spike_valid(spike_valid), .spike_ready(spike_ready),
    .spike_neuron_id(spike_neuron_id), .spike_polarity(spike_polarity),
    .spike_timestamp(spike_timestamp), .fifo_count(fifo_count),
    .drop_count(drop_count), .busy(busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic expectSpike(input logic [11:0] id, input logic pol, input logic [15:0] ts);
    expQ.push_back({id, pol, ts});
  endtask

  // Called at posedge+1; drives a one-cycle strobe and returns at the next posedge+1.
  task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y,
                               input logic [15:0] ts, input logic pol);
    event_x = x; event_y = y; event_timestamp = ts; event_polarity = pol;
    new_event = 1'b1;
    @(posedge clk); #1;
    new_event = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  always @(negedge clk) begin
    if (rst_n && spike_valid && spike_ready) begin
      logic [28:0] exp_s;
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_spike: got id=%0d pol=%0d ts=%0d, expected none",
                 spike_neuron_id, spike_polarity, spike_timestamp);
      end else begin
        exp_s = expQ.pop_front();
        if ({spike_neuron_id, spike_polarity, spike_timestamp} !== exp_s) begin
          errors++;
          $display("[TB] FAIL spike: got id=%0d pol=%0d ts=%0d, expected id=%0d pol=%0d ts=%0d",
                   spike_neuron_id, spike_polarity, spike_timestamp,
                   exp_s[28:17], exp_s[16], exp_s[15:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n = 1'b0; enable = 1'b1; flush = 1'b0; new_event = 1'b0;
    event_x = '0; event_y = '0; event_timestamp = '0; event_polarity = 1'b0;
    spike_ready = 1'b0;
    idle(2);
    checkOutput("reset_valid", spike_valid, 0);
    checkOutput("reset_fifo_count", fifo_count, 0);
    checkOutput("reset_drop_count", drop_count, 0);
    checkOutput("reset_busy", busy, 0);
    rst_n = 1'b1;
    idle(1);

    // Single event: latency and pooled ID {22>>2, 37>>2} = 5*64+9
    spike_ready = 1'b0;
    expectSpike(12'd329, 1'b1, 16'd100);
    applyStimulus(8'd37, 8'd22, 16'd100, 1'b1);
    checkOutput("lat_fifo_count", fifo_count, 1);
    checkOutput("lat_valid_early", spike_valid, 0);
    idle(1);
    checkOutput("lat_valid", spike_valid, 1);
    checkOutput("lat_id", spike_neuron_id, 329);
    checkOutput("lat_fifo_after_load", fifo_count, 0);
    spike_ready = 1'b1;
    idle(1);
    checkOutput("single_valid_done", spike_valid, 0);
    checkOutput("single_busy_done", busy, 0);

    // Refractory on pixel (8,4) -> id 66
    expectSpike(12'd66, 1'b1, 16'd100);
    expectSpike(12'd66, 1'b1, 16'd108);
    expectSpike(12'd66, 1'b0, 16'd101);
    applyStimulus(8'd8, 8'd4, 16'd100, 1'b1);
    applyStimulus(8'd8, 8'd4, 16'd105, 1'b1);
    applyStimulus(8'd8, 8'd4, 16'd108, 1'b1);
    applyStimulus(8'd8, 8'd4, 16'd101, 1'b0);
    idle(6);
    checkOutput("refr_busy", busy, 0);
    checkOutput("refr_drop", drop_count, 0);
    checkOutput("refr_queue_empty", expQ.size(), 0);

    // Timestamp wrap on pixel (100,200) -> id 50*64+25
    expectSpike(12'd3225, 1'b0, 16'd65533);
    expectSpike(12'd3225, 1'b0, 16'd6);
    applyStimulus(8'd100, 8'd200, 16'd65533, 1'b0);
    applyStimulus(8'd100, 8'd200, 16'd2, 1'b0);
    applyStimulus(8'd100, 8'd200, 16'd6, 1'b0);
    enable = 1'b0;
    applyStimulus(8'd1, 8'd1, 16'd500, 1'b1);
    enable = 1'b1;
    idle(6);
    checkOutput("wrap_busy", busy, 0);
    checkOutput("wrap_queue_empty", expQ.size(), 0);

    // Backpressure: 20 distinct events, y=40 -> id 640+i
    spike_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i < 17) expectSpike(12'(640 + i), i[0], 16'(1000 + i));
      applyStimulus(8'(4 * i), 8'd40, 16'(1000 + i), i[0]);
    end
    checkOutput("full_fifo_count", fifo_count, 16);
    checkOutput("full_drop_count", drop_count, 3);
    checkOutput("full_valid", spike_valid, 1);
    checkOutput("full_held_id", spike_neuron_id, 640);
    spike_ready = 1'b1;
    idle(17);
    checkOutput("drain_valid", spike_valid, 0);
    checkOutput("drain_busy", busy, 0);
    checkOutput("drain_queue_empty", expQ.size(), 0);

    // Flush with buffered events, y=100 -> id 25*64+30+j
    spike_ready = 1'b0;
    for (int j = 0; j < 5; j++)
      applyStimulus(8'(120 + 4 * j), 8'd100, 16'(2000 + j), 1'b1);
    idle(1);
    checkOutput("preflush_valid", spike_valid, 1);
    checkOutput("preflush_fifo_count", fifo_count, 4);
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    checkOutput("flush_valid", spike_valid, 0);
    checkOutput("flush_fifo_count", fifo_count, 0);
    checkOutput("flush_drop_count", drop_count, 3);
    checkOutput("flush_busy", busy, 0);
    spike_ready = 1'b1;
    expectSpike(12'd1634, 1'b1, 16'd2005);
    applyStimulus(8'd136, 8'd100, 16'd2005, 1'b1);
    idle(4);
    checkOutput("postflush_busy", busy, 0);
    checkOutput("postflush_queue_empty", expQ.size(), 0);

    // Asynchronous reset mid-burst
    spike_ready = 1'b0;
    applyStimulus(8'd10, 8'd10, 16'd3000, 1'b1);
    applyStimulus(8'd20, 8'd10, 16'd3001, 1'b1);
    applyStimulus(8'd30, 8'd10, 16'd3002, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("areset_valid", spike_valid, 0);
    checkOutput("areset_fifo_count", fifo_count, 0);
    checkOutput("areset_drop_count", drop_count, 0);
    checkOutput("areset_id", spike_neuron_id, 0);
    checkOutput("areset_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    spike_ready = 1'b1;
    idle(4);
    checkOutput("postreset_valid", spike_valid, 0);
    expectSpike(12'd203, 1'b0, 16'd3100);
    applyStimulus(8'd44, 8'd12, 16'd3100, 1'b0);
    idle(4);
    checkOutput("postreset_busy", busy, 0);
    checkOutput("final_queue_empty", expQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
